// File: rtl/i2c_arb_pkg.sv
// Shared types for the two-requester I2C master arbiter: FSM states,
// requester index and watchdog counter width.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  localparam int unsigned WDOG_W = 20;

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Idle-owner watchdog: counts consecutive enabled cycles; expired is a
// combinational strobe in the cycle the count sits at TIMEOUT_CYCLES-1.
module i2c_arb_watchdog
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters; grant
// one cycle after request, combinational command/status passthrough to owner.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r0_req,
  input  logic       r0_ena,
  input  logic [6:0] r0_addr,
  input  logic       r0_rw,
  input  logic [7:0] r0_data_wr,
  output logic       r0_gnt,
  output logic       r0_busy,
  output logic [7:0] r0_data_rd,
  output logic       r0_ack_error,
  input  logic       r1_req,
  input  logic       r1_ena,
  input  logic [6:0] r1_addr,
  input  logic       r1_rw,
  input  logic [7:0] r1_data_wr,
  output logic       r1_gnt,
  output logic       r1_busy,
  output logic [7:0] r1_data_rd,
  output logic       r1_ack_error,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_data_rd,
  input  logic       i2c_ack_error,
  output logic       arb_busy,
  output logic       timeout_pulse
);

  arb_state_e state_q, state_d;
  req_idx_t   owner_q, owner_d;
  req_idx_t   last_q, last_d;
  logic [1:0] lock_q, lock_d;
  logic       start_q, start_d;

  logic [1:0] req, elig;
  logic       own, own_req, own_ena, wd_expired;

  assign req     = {r1_req, r0_req};
  assign elig    = req & ~lock_q;
  assign own     = (state_q == ST_OWN);
  assign own_req = owner_q ? r1_req : r0_req;
  assign own_ena = owner_q ? r1_ena : r0_ena;

  i2c_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (own && !i2c_busy && !own_ena),
    .clear  (!own),
    .expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    lock_d        = lock_q & req;
    start_d       = 1'b1;
    timeout_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start_q holds off the first grant for a full cycle after reset release
        if (start_q) begin
          if (elig == 2'b11) begin
            state_d = ST_OWN;
            owner_d = ~last_q;
          end else if (elig[0]) begin
            state_d = ST_OWN;
            owner_d = 1'b0;
          end else if (elig[1]) begin
            state_d = ST_OWN;
            owner_d = 1'b1;
          end
        end
      end
      ST_OWN: begin
        // voluntary release takes priority over a coincident watchdog expiry
        if (!own_req) begin
          state_d = ST_DRAIN;
          last_d  = owner_q;
        end else if (wd_expired) begin
          state_d         = ST_DRAIN;
          last_d          = owner_q;
          timeout_pulse   = 1'b1;
          lock_d[owner_q] = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!i2c_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lock_q  <= 2'b00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      start_q <= start_d;
    end
  end

  assign arb_busy = (state_q != ST_IDLE);
  assign r0_gnt   = own && !owner_q;
  assign r1_gnt   = own && owner_q;

  always_comb begin
    i2c_ena     = 1'b0;
    i2c_addr    = '0;
    i2c_rw      = 1'b0;
    i2c_data_wr = '0;
    if (own) begin
      i2c_ena     = own_ena;
      i2c_addr    = owner_q ? r1_addr : r0_addr;
      i2c_rw      = owner_q ? r1_rw : r0_rw;
      i2c_data_wr = owner_q ? r1_data_wr : r0_data_wr;
    end
  end

  assign r0_busy      = r0_gnt ? i2c_busy : 1'b1;
  assign r0_data_rd   = r0_gnt ? i2c_data_rd : 8'h00;
  assign r0_ack_error = r0_gnt & i2c_ack_error;
  assign r1_busy      = r1_gnt ? i2c_busy : 1'b1;
  assign r1_data_rd   = r1_gnt ? i2c_data_rd : 8'h00;
  assign r1_ack_error = r1_gnt & i2c_ack_error;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: cycle-by-cycle vector table followed by
// hand-written tie, drain, watchdog and mid-transaction reset sequences.
module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r0_req, r0_ena, r0_rw;
  logic [6:0] r0_addr;
  logic [7:0] r0_data_wr;
  logic       r0_gnt, r0_busy, r0_ack_error;
  logic [7:0] r0_data_rd;
  logic       r1_req, r1_ena, r1_rw;
  logic [6:0] r1_addr;
  logic [7:0] r1_data_wr;
  logic       r1_gnt, r1_busy, r1_ack_error;
  logic [7:0] r1_data_rd;
  logic       i2c_ena, i2c_rw;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_wr;
  logic       i2c_busy, i2c_ack_error;
  logic [7:0] i2c_data_rd;
  logic       arb_busy, timeout_pulse;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r0_req       (r0_req),
    .r0_ena       (r0_ena),
    .r0_addr      (r0_addr),
    .r0_rw        (r0_rw),
    .r0_data_wr   (r0_data_wr),
    .r0_gnt       (r0_gnt),
    .r0_busy      (r0_busy),
    .r0_data_rd   (r0_data_rd),
    .r0_ack_error (r0_ack_error),
    .r1_req       (r1_req),
    .r1_ena       (r1_ena),
    .r1_addr      (r1_addr),
    .r1_rw        (r1_rw),
    .r1_data_wr   (r1_data_wr),
    .r1_gnt       (r1_gnt),
    .r1_busy      (r1_busy),
    .r1_data_rd   (r1_data_rd),
    .r1_ack_error (r1_ack_error),
    .i2c_ena      (i2c_ena),
    .i2c_addr     (i2c_addr),
    .i2c_rw       (i2c_rw),
    .i2c_data_wr  (i2c_data_wr),
    .i2c_busy     (i2c_busy),
    .i2c_data_rd  (i2c_data_rd),
    .i2c_ack_error(i2c_ack_error),
    .arb_busy     (arb_busy),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic       r0_req;
    logic       r1_req;
    logic       r0_ena;
    logic       r1_ena;
    logic       busy;
    logic [1:0] gnt;    // {r1_gnt, r0_gnt}
    logic       ena;
    logic [6:0] addr;
    logic [1:0] rbusy;  // {r1_busy, r0_busy}
    logic       arb;
    logic [7:0] rd1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    r0_req   = 1'b0; r0_ena = 1'b0;
    r1_req   = 1'b0; r1_ena = 1'b0;
    i2c_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    r0_addr = 7'h76; r0_rw = 1'b1; r0_data_wr = 8'hA5;
    r1_addr = 7'h38; r1_rw = 1'b0; r1_data_wr = 8'h5A;
    i2c_data_rd = 8'hC3; i2c_ack_error = 1'b1;

    //           r0q r1q r0e r1e bsy  gnt    ena  addr   rbusy  arb  rd1
    vecs[0]  = '{0,  0,  0,  0,  0,  2'b00, 0,  7'h00, 2'b11, 0,  8'h00};
    vecs[1]  = '{1,  0,  0,  0,  0,  2'b00, 0,  7'h00, 2'b11, 0,  8'h00};
    vecs[2]  = '{1,  1,  0,  1,  1,  2'b01, 0,  7'h76, 2'b11, 1,  8'h00};
    vecs[3]  = '{1,  1,  1,  1,  1,  2'b01, 1,  7'h76, 2'b11, 1,  8'h00};
    vecs[4]  = '{1,  1,  1,  1,  0,  2'b01, 1,  7'h76, 2'b10, 1,  8'h00};
    vecs[5]  = '{0,  1,  0,  1,  1,  2'b01, 0,  7'h76, 2'b11, 1,  8'h00};
    vecs[6]  = '{0,  1,  0,  1,  1,  2'b00, 0,  7'h00, 2'b11, 1,  8'h00};
    vecs[7]  = '{0,  1,  0,  1,  0,  2'b00, 0,  7'h00, 2'b11, 1,  8'h00};
    vecs[8]  = '{0,  1,  0,  1,  0,  2'b00, 0,  7'h00, 2'b11, 0,  8'h00};
    vecs[9]  = '{0,  1,  0,  1,  0,  2'b10, 1,  7'h38, 2'b01, 1,  8'hC3};
    vecs[10] = '{0,  0,  0,  1,  0,  2'b10, 1,  7'h38, 2'b01, 1,  8'hC3};
    vecs[11] = '{0,  0,  0,  0,  0,  2'b00, 0,  7'h00, 2'b11, 1,  8'h00};
    vecs[12] = '{0,  0,  0,  0,  0,  2'b00, 0,  7'h00, 2'b11, 0,  8'h00};

    // ---- table: single request, pending request, drain, handover ----
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc();
      r0_req = vecs[i].r0_req; r1_req = vecs[i].r1_req;
      r0_ena = vecs[i].r0_ena; r1_ena = vecs[i].r1_ena;
      i2c_busy = vecs[i].busy;
      #4;
      chk($sformatf("v%0d gnt", i), {r1_gnt, r0_gnt}, vecs[i].gnt);
      chk($sformatf("v%0d i2c_ena", i), i2c_ena, vecs[i].ena);
      chk($sformatf("v%0d i2c_addr", i), i2c_addr, vecs[i].addr);
      chk($sformatf("v%0d i2c_data_wr", i), i2c_data_wr,
          vecs[i].gnt[0] ? 8'hA5 : (vecs[i].gnt[1] ? 8'h5A : 8'h00));
      chk($sformatf("v%0d i2c_rw", i), i2c_rw, vecs[i].gnt[0]);
      chk($sformatf("v%0d rbusy", i), {r1_busy, r0_busy}, vecs[i].rbusy);
      chk($sformatf("v%0d arb_busy", i), arb_busy, vecs[i].arb);
      chk($sformatf("v%0d r1_data_rd", i), r1_data_rd, vecs[i].rd1);
      chk($sformatf("v%0d r0_data_rd", i), r0_data_rd, vecs[i].gnt[0] ? 8'hC3 : 8'h00);
      chk($sformatf("v%0d ack_err", i), {r1_ack_error, r0_ack_error}, vecs[i].gnt);
      chk($sformatf("v%0d timeout", i), timeout_pulse, 1'b0);
    end

    // ---- tie after reset, then drain with r0 pending ----
    do_reset();
    cyc(); r0_req = 1; r1_req = 1; r0_ena = 1; r1_ena = 1; #4;
    chk("tie c0 gnt", {r1_gnt, r0_gnt}, 2'b00);
    cyc(); #4;
    chk("tie r0 wins", {r1_gnt, r0_gnt}, 2'b01);
    cyc(); r0_req = 0; #4;
    chk("tie release cycle", {r1_gnt, r0_gnt}, 2'b01);
    cyc(); #4;
    chk("tie drain gnt", {r1_gnt, r0_gnt}, 2'b00);
    chk("tie drain arb", arb_busy, 1'b1);
    cyc(); #4;
    chk("tie idle gnt", {r1_gnt, r0_gnt}, 2'b00);
    cyc(); #4;
    chk("tie r1 gnt", {r1_gnt, r0_gnt}, 2'b10);
    chk("tie r1 addr", i2c_addr, 7'h38);
    cyc(); r0_req = 1; i2c_busy = 1; r1_req = 0; #4;
    chk("drn own last", r1_gnt, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(); #4;
      chk($sformatf("drn%0d ena", i), i2c_ena, 1'b0);
      chk($sformatf("drn%0d gnt", i), {r1_gnt, r0_gnt}, 2'b00);
      chk($sformatf("drn%0d addr", i), i2c_addr, 7'h00);
    end
    cyc(); i2c_busy = 0; #4;
    chk("drn busy fall gnt", r0_gnt, 1'b0);
    cyc(); #4;
    chk("drn idle gnt", r0_gnt, 1'b0);
    cyc(); #4;
    chk("drn r0 gnt", r0_gnt, 1'b1);
    chk("drn r0 addr", i2c_addr, 7'h76);

    // ---- watchdog expiry, lockout, and release-wins ----
    do_reset();
    cyc(); r0_req = 1; #4;
    for (int i = 1; i <= 8; i++) begin
      cyc(); #4;
      chk($sformatf("wd idle%0d gnt", i), r0_gnt, 1'b1);
      chk($sformatf("wd idle%0d pulse", i), timeout_pulse, (i == 8) ? 1'b1 : 1'b0);
    end
    cyc(); #4;
    chk("wd drain gnt", r0_gnt, 1'b0);
    chk("wd drain pulse", timeout_pulse, 1'b0);
    chk("wd drain arb", arb_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #4;
      chk($sformatf("wd lock%0d gnt", i), r0_gnt, 1'b0);
    end
    cyc(); r0_req = 0; #4;
    cyc(); r0_req = 1; #4;
    chk("wd relock idle gnt", r0_gnt, 1'b0);
    cyc(); #4;
    chk("wd regrant", r0_gnt, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(); #4;
    end
    cyc(); r0_req = 0; #4;
    chk("wd release wins pulse", timeout_pulse, 1'b0);
    cyc(); #4;
    chk("wd release drain pulse", timeout_pulse, 1'b0);
    chk("wd release drain arb", arb_busy, 1'b1);

    // ---- asynchronous reset in the middle of an owned transaction ----
    do_reset();
    cyc(); r0_req = 1; r0_ena = 1; #4;
    cyc(); #4;
    chk("rst pre ena", i2c_ena, 1'b1);
    #1 reset_n = 0;
    #1;
    chk("rst i2c_ena", i2c_ena, 1'b0);
    chk("rst r0_gnt", r0_gnt, 1'b0);
    chk("rst r0_busy", r0_busy, 1'b1);
    chk("rst r1_busy", r1_busy, 1'b1);
    chk("rst r0_data_rd", r0_data_rd, 8'h00);
    chk("rst r0_ack", r0_ack_error, 1'b0);
    chk("rst i2c_addr", i2c_addr, 7'h00);
    chk("rst i2c_data_wr", i2c_data_wr, 8'h00);
    chk("rst arb_busy", arb_busy, 1'b0);
    chk("rst timeout", timeout_pulse, 1'b0);
    @(negedge clk) reset_n = 1;
    cyc(); #4;
    chk("rst first edge gnt", r0_gnt, 1'b0);
    cyc(); #4;
    chk("rst second edge gnt", r0_gnt, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
